div_seq_unit: RTL and testbench
===============================

// Module: div_seq_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider in the execute stage of the 5-stage MIPS pipeline.
//  Produces the div_stallE request that the hazard unit folds into its global stall.
//  Holds its result until the E-stage instruction actually advances.
//  Aborts cleanly when the E stage is flushed.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  div_startE    in   1      E-stage instruction is DIV/DIVU (level, held while E stalled)
//  div_signedE   in   1      1=DIV (two's complement), 0=DIVU
//  src_aE        in   WIDTH  dividend (rs)
//  src_bE        in   WIDTH  divisor (rt)
//  stallE        in   1      global E-stage stall from hazard (includes div_stallE)
//  flushE        in   1      E-stage flush from hazard
//  div_stallE    out  1      stall request to hazard
//  div_validE    out  1      div_hiE/div_loE valid for the current E instruction
//  div_hiE       out  WIDTH  remainder (to HI)
//  div_loE       out  WIDTH  quotient (to LO)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, div_hiE=div_loE=0, div_validE=0. div_stallE=0 unless IDLE&start.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE & div_startE & ~flushE:
//    - latch |a|, |b| (abs only if signed), sign_q=a[msb]^b[msb], sign_r=a[msb]
//    - clear partial remainder; counter=0; go BUSY
//  - BUSY: one restoring step per cycle.
//    - {rem,quo} shifted left 1; trial = rem - |b|
//    - if no borrow: rem=trial, quo[0]=1
//    - after WIDTH steps: go DONE and register fixed-up results
//  - div_stallE = (IDLE & div_startE & ~flushE) | (BUSY & ~flushE).
//    - Stall is high for exactly WIDTH+1 cycles (start cycle + WIDTH steps).
//    - div_validE rises in cycle WIDTH+1.
//  - DONE:
//    - div_validE=1, div_stallE=0, results stable
//    - stay while stallE=1 (other stall sources: cache, mult); div_startE is ignored here, no restart
//    - go IDLE when stallE=0 (instruction leaves E)
//    - a following DIV can start next cycle without a bubble
//  - Sign fixup (signed only):
//    - quotient negated if sign_q
//    - remainder negated if sign_r (remainder takes the dividend sign)
//    - 0x80000000 / -1 yields lo=0x80000000, hi=0
//  - Divide by zero: lo=all-ones, hi=src_aE as latched (no fixup), same latency, no exception.
//  - flushE in any state: next state IDLE, div_validE cleared; same-cycle div_stallE masked; flush beats start.
//  - rst has priority over all inputs; a reset mid-division discards the operation.
//  - Operands are sampled only in the start cycle; later changes on src_*E are ignored.
// STRUCTURE
//  - Shared defines header: FSM state encodings (2-bit), WIDTH default.
//  - Counter width is $clog2(WIDTH)+1.
//  - Optional sub-module div_radix2_step: combinational {rem,quo},divisor -> next {rem,quo}.
//  - All other logic in this module; no multiplier or memories.
// TESTING
//  1. DIVU 100/7: div_stallE high 33 cycles, then div_validE=1, lo=14, hi=2.
//  2. DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 7/-2: lo=0xFFFFFFFD, hi=1.
//  3. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. DIVU 5/0: lo=0xFFFFFFFF, hi=5.
//  4. flushE pulse at BUSY step 10: div_stallE=0 that cycle, IDLE next cycle, div_validE never rises.
//  5. After DONE, hold stallE=1 for 5 cycles with div_startE=1:
//     - no restart; results constant
//     - stallE=0 -> IDLE; back-to-back DIVU 9/3 then completes with lo=3, hi=0.
//  6. rst at BUSY step 20: all outputs 0 next cycle; a new 50/5 then gives lo=10, hi=0.

Source files
------------

// File: rtl/div_seq_unit_pkg.sv
// rtl/div_seq_unit_pkg.sv - shared width default and FSM encodings for the sequential divider
package div_seq_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_seq_unit_radix2_step.sv
// rtl/div_seq_unit_radix2_step.sv - one combinational restoring-division step
module div_radix2_step
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Extra top bit keeps the shifted remainder exact when the divisor is near 2^WIDTH.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - multi-cycle radix-2 restoring divider for the E stage
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             stallE,
    input  logic             flushE,
    output logic             div_stallE,
    output logic             div_validE,
    output logic [WIDTH-1:0] div_hiE,
    output logic [WIDTH-1:0] div_loE
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q, dividend_q;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] a_abs, b_abs, hi_fix, lo_fix;
    logic             sign_q, sign_r;
    logic             start_ok, last_step;

    assign a_abs     = (div_signedE && src_aE[WIDTH-1]) ? -src_aE : src_aE;
    assign b_abs     = (div_signedE && src_bE[WIDTH-1]) ? -src_bE : src_bE;
    assign start_ok  = (state == ST_IDLE) && div_startE && !flushE;
    assign last_step = (state == ST_BUSY) && (cnt == CNT_W'(WIDTH - 1));

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Divide by zero bypasses sign fixup and returns the raw dividend as remainder.
    always_comb begin
        lo_fix = sign_q ? -quo_nx : quo_nx;
        hi_fix = sign_r ? -rem_nx : rem_nx;
        if (divisor_q == '0) begin
            lo_fix = '1;
            hi_fix = dividend_q;
        end
    end

    always_comb begin
        state_next = state;
        div_stallE = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_BUSY;
                    div_stallE = 1'b1;
                end
            end
            ST_BUSY: begin
                div_stallE = !flushE;
                if (last_step) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!stallE) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flushE) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_hiE    <= '0;
            div_loE    <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                rem_q      <= '0;
                quo_q      <= a_abs;
                divisor_q  <= b_abs;
                dividend_q <= src_aE;
                sign_q     <= div_signedE && (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                sign_r     <= div_signedE && src_aE[WIDTH-1];
                cnt        <= '0;
            end else if (state == ST_BUSY) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt   <= cnt + 1'b1;
                if (last_step && !flushE) begin
                    div_hiE <= hi_fix;
                    div_loE <= lo_fix;
                end
            end
        end
    end

    assign div_validE = (state == ST_DONE);

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - scoreboard bench for div_seq_unit
module tb_div_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, div_startE, div_signedE, flushE, ext_stall;
    logic [W-1:0] src_aE, src_bE, div_hiE, div_loE;
    logic         stallE, div_stallE, div_validE;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic         mon_prev;
    logic [63:0]  mon_e;

    assign stallE = div_stallE | ext_stall;

    always #5 clk = ~clk;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_startE  (div_startE),
        .div_signedE (div_signedE),
        .src_aE      (src_aE),
        .src_bE      (src_bE),
        .stallE      (stallE),
        .flushE      (flushE),
        .div_stallE  (div_stallE),
        .div_validE  (div_validE),
        .div_hiE     (div_hiE),
        .div_loE     (div_loE)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic push, input logic [31:0] ehi, input logic [31:0] elo);
        div_startE  = 1'b1;
        div_signedE = sgn;
        src_aE      = a;
        src_bE      = b;
        if (push) exp_q.push_back({ehi, elo});
    endtask

    task automatic wait_done(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (div_stallE) n++;
            else if (div_validE && n > 0) done = 1;
            if (!done) @(negedge clk);
        end
        check({name, "_done"}, done, 1);
        check({name, "_stall_cycles"}, n, 33);
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        @(negedge clk);
        start_div(sgn, a, b, 1'b1, ehi, elo);
        wait_done(name);
        div_startE = 1'b0;
        src_aE     = 32'hDEAD_BEEF;
        src_bE     = 32'h0000_0001;
    endtask

    // Scoreboard monitor: each rising div_validE consumes one expected result.
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (div_validE && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h expected none", div_hiE, div_loE);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_hi", div_hiE, mon_e[63:32]);
                    check("result_lo", div_loE, mon_e[31:0]);
                end
            end
            mon_prev = div_validE;
        end
    end

    initial begin
        bit seen;
        rst = 1'b1; div_startE = 0; div_signedE = 0; flushE = 0; ext_stall = 0;
        src_aE = '0; src_bE = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", div_stallE, 0);
        check("reset_valid", div_validE, 0);
        check("reset_hi", div_hiE, 0);
        check("reset_lo", div_loE, 0);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_div("divu_by0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_div("div_m9_by0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

        // Flush mid-division
        @(negedge clk);
        start_div(1'b0, 32'd1000, 32'd3, 1'b0, 0, 0);
        repeat (10) @(negedge clk);
        flushE = 1'b1; div_startE = 1'b0;
        #1 check("flush_stall_masked", div_stallE, 0);
        @(negedge clk);
        flushE = 1'b0;
        #1;
        check("flush_idle_stall", div_stallE, 0);
        check("flush_idle_valid", div_validE, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1 if (div_validE) seen = 1;
        end
        check("flush_no_valid", seen, 0);

        // Flush beats start in IDLE
        @(negedge clk);
        div_startE = 1'b1; flushE = 1'b1;
        #1 check("flush_beats_start", div_stallE, 0);
        @(negedge clk);
        div_startE = 1'b0; flushE = 1'b0;
        #1 check("flush_beats_start_next", div_stallE, 0);

        // Hold in DONE under external stall, then back-to-back start
        @(negedge clk);
        start_div(1'b0, 32'd1000, 32'd7, 1'b1, 32'd6, 32'd142);
        wait_done("divu_1000_7");
        ext_stall = 1'b1;
        src_aE = 32'd77; src_bE = 32'd11;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("hold_valid", div_validE, 1);
            check("hold_no_restart", div_stallE, 0);
            check("hold_lo", div_loE, 142);
            check("hold_hi", div_hiE, 6);
        end
        ext_stall = 1'b0;
        start_div(1'b0, 32'd9, 32'd3, 1'b1, 32'd0, 32'd3);
        @(negedge clk);
        #1 check("b2b_stall_next_cycle", div_stallE, 1);
        wait_done("divu_9_3");
        div_startE = 1'b0;

        // Reset mid-division
        @(negedge clk);
        start_div(1'b0, 32'd1000, 32'd7, 1'b0, 0, 0);
        repeat (21) @(negedge clk);
        rst = 1'b1; div_startE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_stall", div_stallE, 0);
        check("rst_mid_valid", div_validE, 0);
        check("rst_mid_hi", div_hiE, 0);
        check("rst_mid_lo", div_loE, 0);
        run_div("divu_50_5", 1'b0, 32'd50, 32'd5, 32'd0, 32'd10);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
